termbuffer_grid: RTL and testbench

Parametrised successor to the fixed-size terminal buffer. Holds a ROWS x COLS character grid with a cursor. Accepts one input byte at a time, applies printable or control semantics (wrap, scroll, CR, LF, BS), then streams a full-screen refresh to a byte-wide downstream sink. The refresh is a home escape followed by each row terminated with CR LF. Sits between the host/UART byte source and the serial TX path.

---
 rtl/termbuffer_pkg.sv | 29 ++
 rtl/termbuffer_ram.sv | 24 ++
 rtl/termbuffer_grid.sv | 231 +++++++++++++++++++++++
 tb/tb_termbuffer_grid.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/termbuffer_pkg.sv
// Shared constants and types for the terminal grid buffer: escape/control bytes,
// top-level FSM encoding and the refresh-stream sub-phases.
package termbuffer_pkg;

    localparam logic [7:0] ESC         = 8'h1B;
    localparam logic [7:0] CSI_BRACKET = 8'h5B;
    localparam logic [7:0] HOME_H      = 8'h48;
    localparam logic [7:0] CR          = 8'h0D;
    localparam logic [7:0] LF          = 8'h0A;
    localparam logic [7:0] BS          = 8'h08;

    typedef logic [1:0] state_t;
    localparam state_t CLEAR  = 2'd0;
    localparam state_t IDLE   = 2'd1;
    localparam state_t UPDATE = 2'd2;
    localparam state_t DUMP   = 2'd3;

    typedef enum logic [1:0] {HDR, CELL, EOL_CR, EOL_LF} dump_phase_e;

    // Cursor-home sequence, one byte per index.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return ESC;
            2'd1:    return CSI_BRACKET;
            default: return HOME_H;
        endcase
    endfunction

endpackage

// File: rtl/termbuffer_ram.sv
// Character grid storage: one write port and one read port with a registered
// (one-cycle latency) output.
module termbuffer_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/termbuffer_grid.sv
// ROWS x COLS terminal grid with cursor, wrap/scroll/CR/LF/BS handling and a
// full-screen refresh streamed to a byte sink after every accepted input byte.
module termbuffer_grid
    import termbuffer_pkg::*;
#(
    parameter int         COLS = 16,
    parameter int         ROWS = 8,
    parameter logic [7:0] FILL = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                i_byte,
    input  logic                      i_byte_v,
    output logic [7:0]                o_byte,
    output logic                      o_byte_v,
    input  logic                      i_byte_done,
    output logic                      o_busy,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [RW:0]   ROWS_W    = (RW + 1)'(ROWS);

    state_t        state;
    dump_phase_e   phase, n_phase;
    logic [1:0]    hdr_idx, n_hdr;
    logic [RW-1:0] top, d_row, n_row, cur_prow;
    logic [CW-1:0] d_col, n_col, fill_col, nxt_col;
    logic [AW-1:0] clr_cnt, waddr, raddr;
    logic [7:0]    ch, wdata, rdata, n_val;
    logic          scrolling, we, adv, printable, go_dump, last_item;
    logic          done_r, done_q, ack_edge;

    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] t, input logic [RW-1:0] r);
        logic [RW:0] s;
        s = {1'b0, t} + {1'b0, r};
        if (s >= ROWS_W) s = s - ROWS_W;
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
        return AW'(prow) * COLS_A + AW'(col);
    endfunction

    assign o_busy    = (state != IDLE);
    assign cur_prow  = phys_row(top, cursor_row);
    assign printable = (ch >= 8'h20) && (ch <= 8'h7E);
    // Sink handshake: o_byte is stable whenever o_byte_v is high; a 0->1 edge of the
    // registered i_byte_done retires it, o_byte_v drops for at least one cycle, then the
    // next byte is offered. Pulse length does not matter, only the rising edge.
    assign ack_edge  = done_r & ~done_q;
    assign last_item = (phase == EOL_LF) && (d_row == ROW_LAST);

    always_comb begin
        adv     = 1'b0;
        nxt_col = cursor_col;
        if (printable) begin
            if (cursor_col == COL_LAST) begin
                nxt_col = '0;
                adv     = 1'b1;
            end else begin
                nxt_col = cursor_col + 1'b1;
            end
        end else if (ch == CR) begin
            nxt_col = '0;
        end else if (ch == LF) begin
            adv = 1'b1;
        end else if (ch == BS) begin
            nxt_col = (cursor_col == '0) ? '0 : cursor_col - 1'b1;
        end
    end

    assign go_dump = (state == UPDATE) &&
                     ((!scrolling && !(adv && cursor_row == ROW_LAST)) ||
                      (scrolling && fill_col == COL_LAST));

    always_comb begin
        we    = 1'b0;
        waddr = cell_addr(cur_prow, cursor_col);
        wdata = ch;
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = clr_cnt;
            wdata = FILL;
        end else if (state == UPDATE) begin
            if (scrolling) begin
                // cursor row already maps onto the freshly exposed bottom row
                we    = 1'b1;
                waddr = cell_addr(cur_prow, fill_col);
                wdata = FILL;
            end else begin
                we = printable;
            end
        end
    end

    // Successor of the item on the wire; its RAM cell is read while the current byte waits.
    always_comb begin
        n_phase = phase;
        n_hdr   = hdr_idx;
        n_row   = d_row;
        n_col   = d_col;
        case (phase)
            HDR: begin
                if (hdr_idx == 2'd2) begin
                    n_phase = CELL;
                    n_row   = '0;
                    n_col   = '0;
                end else begin
                    n_hdr = hdr_idx + 1'b1;
                end
            end
            CELL: begin
                if (d_col == COL_LAST) n_phase = EOL_CR;
                else                   n_col   = d_col + 1'b1;
            end
            EOL_CR: n_phase = EOL_LF;
            EOL_LF: begin
                n_phase = CELL;
                n_row   = d_row + 1'b1;
                n_col   = '0;
            end
            default: n_phase = HDR;
        endcase
        case (n_phase)
            HDR:     n_val = hdr_byte(n_hdr);
            CELL:    n_val = rdata;
            EOL_CR:  n_val = CR;
            default: n_val = LF;
        endcase
    end

    assign raddr = cell_addr(phys_row(top, n_row), n_col);

    termbuffer_ram #(.DEPTH(N), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            top        <= '0;
            ch         <= '0;
            scrolling  <= 1'b0;
            fill_col   <= '0;
            phase      <= HDR;
            hdr_idx    <= '0;
            d_row      <= '0;
            d_col      <= '0;
            o_byte     <= '0;
            o_byte_v   <= 1'b0;
            done_r     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_r <= i_byte_done;
            done_q <= done_r;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_LAST) state <= IDLE;
                end
                IDLE: begin
                    if (i_byte_v) begin
                        ch    <= i_byte;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (!scrolling) begin
                        cursor_col <= nxt_col;
                        if (adv && cursor_row != ROW_LAST) begin
                            cursor_row <= cursor_row + 1'b1;
                        end else if (adv) begin
                            top       <= (top == ROW_LAST) ? '0 : top + 1'b1;
                            scrolling <= 1'b1;
                            fill_col  <= '0;
                        end
                    end else begin
                        fill_col <= fill_col + 1'b1;
                        if (fill_col == COL_LAST) scrolling <= 1'b0;
                    end
                end
                DUMP: begin
                    if (o_byte_v) begin
                        if (ack_edge) begin
                            o_byte_v <= 1'b0;
                            if (last_item) begin
                                state <= IDLE;
                            end else begin
                                phase   <= n_phase;
                                hdr_idx <= n_hdr;
                                d_row   <= n_row;
                                d_col   <= n_col;
                                o_byte  <= n_val;
                            end
                        end
                    end else begin
                        o_byte_v <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
            if (go_dump) begin
                state    <= DUMP;
                phase    <= HDR;
                hdr_idx  <= '0;
                d_row    <= '0;
                d_col    <= '0;
                o_byte   <= ESC;
                o_byte_v <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_termbuffer_grid.sv
// Self-checking bench for termbuffer_grid: directed scenarios plus random bytes,
// each refresh compared against a logical-screen reference model.
`timescale 1ns/1ps
module tb_termbuffer_grid;

    localparam int         COLS     = 16;
    localparam int         ROWS     = 8;
    localparam logic [7:0] FILL     = 8'h20;
    localparam int         DUMP_LEN = 3 + ROWS * (COLS + 2);

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [7:0]              i_byte = '0;
    logic                    i_byte_v = 1'b0;
    logic [7:0]              o_byte;
    logic                    o_byte_v;
    logic                    i_byte_done = 1'b0;
    logic                    o_busy;
    logic [$clog2(COLS)-1:0] cursor_col;
    logic [$clog2(ROWS)-1:0] cursor_row;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] scr [ROWS][COLS];
    int         mc, mr;
    logic [7:0] exp_q[$];

    termbuffer_grid #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_byte      (i_byte),
        .i_byte_v    (i_byte_v),
        .o_byte      (o_byte),
        .o_byte_v    (o_byte_v),
        .i_byte_done (i_byte_done),
        .o_busy      (o_busy),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = FILL;
        mc = 0;
        mr = 0;
    endtask

    task automatic model_advance();
        if (mr < ROWS - 1) begin
            mr++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++)
                scr[ROWS-1][c] = FILL;
        end
    endtask

    task automatic model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mr][mc] = b;
            if (mc == COLS - 1) begin
                mc = 0;
                model_advance();
            end else begin
                mc++;
            end
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h0A) begin
            model_advance();
        end else if (b == 8'h08) begin
            if (mc > 0) mc--;
        end
    endtask

    task automatic build_expect();
        exp_q.delete();
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        exp_q.push_back(8'h48);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) exp_q.push_back(scr[r][c]);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Called at a negedge; asserts reset for one edge and waits out the clear.
    task automatic do_reset();
        int n;
        rst         = 1'b1;
        i_byte_v    = 1'b0;
        i_byte_done = 1'b0;
        @(negedge clk);
        check("rst_o_byte_v", o_byte_v, 0);
        check("rst_o_byte", o_byte, 0);
        check("rst_busy", o_busy, 1);
        check("rst_cursor_col", cursor_col, 0);
        check("rst_cursor_row", cursor_row, 0);
        rst = 1'b0;
        n   = 0;
        while (o_busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("clear_cycles", n, ROWS * COLS);
        model_clear();
    endtask

    task automatic collect(input int inject_idx, input int abort_idx);
        int   n, hold, k;
        logic seen_drop, busy_drop;
        for (int idx = 0; idx < DUMP_LEN; idx++) begin
            n = 0;
            while (!o_byte_v && n < 50) begin
                n++;
                @(negedge clk);
            end
            check($sformatf("dump_valid[%0d]", idx), o_byte_v, 1);
            if (!o_byte_v) return;
            check($sformatf("dump_byte[%0d]", idx), o_byte, exp_q[idx]);
            if (idx == abort_idx) begin
                do_reset();
                return;
            end
            if (idx == inject_idx) begin
                i_byte   = 8'h5A;
                i_byte_v = 1'b1;
                @(negedge clk);
                i_byte_v = 1'b0;
            end
            repeat ($urandom_range(0, 1)) @(negedge clk);
            check($sformatf("dump_hold[%0d]", idx), {o_byte_v, o_byte}, {1'b1, exp_q[idx]});
            i_byte_done = 1'b1;
            hold        = $urandom_range(1, 2);
            k           = 0;
            seen_drop   = 1'b0;
            busy_drop   = 1'b1;
            do begin
                @(negedge clk);
                k++;
                if (k >= hold) i_byte_done = 1'b0;
                if (!o_byte_v && !seen_drop) begin
                    seen_drop = 1'b1;
                    busy_drop = o_busy;
                end
            end while ((!seen_drop || i_byte_done) && k < 50);
            check($sformatf("ack_drop[%0d]", idx), seen_drop, 1);
            check($sformatf("busy_after[%0d]", idx), busy_drop, (idx == DUMP_LEN - 1) ? 0 : 1);
            @(negedge clk);
        end
        check("cursor_col", cursor_col, mc);
        check("cursor_row", cursor_row, mr);
    endtask

    task automatic send_byte(input logic [7:0] b, input int inject_idx, input int abort_idx);
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("idle_before_send", o_busy, 0);
        i_byte   = b;
        i_byte_v = 1'b1;
        @(negedge clk);
        i_byte_v = 1'b0;
        model_apply(b);
        build_expect();
        collect(inject_idx, abort_idx);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, -1, -1);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] odd_codes [4];
        odd_codes = '{8'h00, 8'h7F, 8'hFF, 8'h1B};

        @(negedge clk);

        // Blank screen refresh
        do_reset();
        send(8'h20);

        // Single printable character
        do_reset();
        send(8'h41);

        // Wrap at end of row
        do_reset();
        repeat (17) send(8'h78);

        // Scroll pushes the top row off
        do_reset();
        send(8'h51);
        repeat (7) send(8'h0A);
        send(8'h52);
        send(8'h0A);

        // CR overwrite and BS saturation
        do_reset();
        send(8'h61);
        send(8'h62);
        send(8'h0D);
        send(8'h63);
        send(8'h08);
        send(8'h08);

        // Input while busy is dropped; reset mid-refresh aborts it
        send_byte(8'h6B, 20, -1);
        send(8'h6E);
        send_byte(8'h6D, -1, 50);
        send(8'h20);

        // Random mix, weighted towards line feeds so scrolling recurs
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = 8'($urandom_range(8'h21, 8'h7E));
                4:          b = 8'h0D;
                5, 6, 7:    b = 8'h0A;
                8:          b = 8'h08;
                default:    b = odd_codes[$urandom_range(0, 3)];
            endcase
            send(b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
